// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared states, trigger modes, constants and stream-word packing
// for the ADC capture sequencer.
package adc_capture_pkg;
  localparam int MIN_FRAME_LEN = 2;
  localparam int TDATA_W = 32;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3
  } state_t;
  typedef enum logic [1:0] {
    TRIG_IMM  = 2'd0,
    TRIG_THR  = 2'd1,
    TRIG_EXT  = 2'd2,
    TRIG_RSVD = 2'd3
  } trig_mode_t;
  // Channel B lands in the upper half, channel A in the lower half; both are
  // expected already sign-extended to 16 bits.
  function automatic logic [TDATA_W-1:0] pack_sample(input logic [TDATA_W/2-1:0] a,
                                                     input logic [TDATA_W/2-1:0] b);
    return {b, a};
  endfunction
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous show-ahead FIFO with occupancy output.
// Ports: clk/reset (async, active-high), push_i/data_i write side, pop_i read side,
//        data_o (head entry, valid while !empty_o), empty_o, count_o (occupancy 0..DEPTH).
module capture_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign do_pop  = pop_i && cnt_q != '0;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
  assign data_o  = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: trigger-qualified, decimating dual-channel ADC capture sequencer
// feeding AXI-Stream through a drop-on-full FIFO.
// Ports: clk/reset (async, active-high); cfg_* arm/abort pulses and capture config
//        (latched on arm); adc_data_a/b + adc_valid non-stallable sample source; ext_trig;
//        m_axis_* output stream {sext(b),sext(a)} with tlast; busy/done/aborted pulses,
//        sticky overflow, saturating drop_count, state_o debug state.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_arm,
  input  logic                 cfg_abort,
  input  logic [1:0]           cfg_mode,
  input  logic [DATA_W-1:0]    cfg_threshold,
  input  logic [LEN_W-1:0]     cfg_frame_len,
  input  logic [7:0]           cfg_decim,
  input  logic                 cfg_continuous,
  input  logic [DATA_W-1:0]    adc_data_a,
  input  logic [DATA_W-1:0]    adc_data_b,
  input  logic                 adc_valid,
  input  logic                 ext_trig,
  output logic [TDATA_W-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 overflow,
  output logic [LEN_W-1:0]     drop_count,
  output logic [2:0]           state_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [DATA_W-1:0] A_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                   state_q, state_d;
  trig_mode_t               mode_q, mode_d;
  logic signed [DATA_W-1:0] thr_q, thr_d, prev_a_q, prev_a_d, cur_a;
  logic [LEN_W-1:0]         len_q, len_d, scnt_q, scnt_d, drop_q, drop_d;
  logic [7:0]               decim_q, decim_d, dcnt_q, dcnt_d;
  logic                     cont_q, cont_d, abort_q, abort_d, pend_q, pend_d, ovf_q, ovf_d;
  logic                     ext_q;
  logic                     ext_edge, trig, cap_tick, is_final, take, fits, push, drop;
  logic                     arm_ok, rearm, pop, fifo_empty;
  logic [CW-1:0]            occ;
  logic [TDATA_W:0]         fifo_din, fifo_dout;

  assign cur_a    = adc_data_a;
  assign ext_edge = ext_trig & ~ext_q;
  // Trigger qualification ignores decimation; mode 3 was folded into mode 0 at arm time.
  assign trig     = adc_valid && (mode_q == TRIG_THR ? (prev_a_q < thr_q && cur_a >= thr_q) :
                                  mode_q == TRIG_EXT ? (pend_q || ext_edge) : 1'b1);
  assign cap_tick = adc_valid && dcnt_q == decim_q;
  // Frame length is clamped to >= 2, so the trigger sample is never the final one.
  assign is_final = state_q == CAPTURE && scnt_q == len_q - LEN_W'(1);
  assign take     = !cfg_abort && (state_q == ARMED ? trig : state_q == CAPTURE && cap_tick);
  // One slot is held back for the tlast sample so a frame end is never dropped.
  assign fits     = is_final ? occ < CW'(FIFO_DEPTH) : occ < CW'(FIFO_DEPTH - 1);
  assign push     = take && fits;
  assign drop     = take && !fits;
  assign arm_ok   = state_q == IDLE && cfg_arm && !cfg_abort;
  assign rearm    = state_q == DRAIN && fifo_empty && cont_q && !abort_q;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign fifo_din = {is_final, pack_sample(16'($signed(adc_data_a)), 16'($signed(adc_data_b)))};

  capture_fifo #(
    .W    (TDATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (fifo_din),
    .pop_i  (pop),
    .data_o (fifo_dout),
    .empty_o(fifo_empty),
    .count_o(occ)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[TDATA_W-1:0];
  assign m_axis_tlast  = fifo_dout[TDATA_W];
  assign busy          = state_q != IDLE;
  // DRAIN completes in the first cycle the FIFO is empty, i.e. one cycle after the last beat.
  assign done          = state_q == DRAIN && fifo_empty && !abort_q;
  assign aborted       = (state_q == ARMED && cfg_abort) || (state_q == DRAIN && fifo_empty && abort_q);
  assign overflow      = ovf_q;
  assign drop_count    = drop_q;
  assign state_o       = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = arm_ok ? ARMED : IDLE;
      ARMED:   state_d = cfg_abort ? IDLE : take ? CAPTURE : ARMED;
      CAPTURE: state_d = (cfg_abort || (take && is_final)) ? DRAIN : CAPTURE;
      DRAIN:   state_d = !fifo_empty ? DRAIN : (cont_q && !abort_q) ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    thr_d    = thr_q;
    len_d    = len_q;
    decim_d  = decim_q;
    cont_d   = cont_q;
    abort_d  = abort_q;
    pend_d   = pend_q;
    prev_a_d = prev_a_q;
    scnt_d   = scnt_q;
    dcnt_d   = dcnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (arm_ok) begin
      mode_d  = cfg_mode == TRIG_RSVD ? TRIG_IMM : trig_mode_t'(cfg_mode);
      thr_d   = cfg_threshold;
      len_d   = cfg_frame_len < LEN_W'(MIN_FRAME_LEN) ? LEN_W'(MIN_FRAME_LEN) : cfg_frame_len;
      decim_d = cfg_decim;
      cont_d  = cfg_continuous;
      abort_d = 1'b0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end
    if (arm_ok || rearm) begin
      prev_a_d = A_MIN;
      pend_d   = 1'b0;
    end
    if (state_q == ARMED) begin
      if (adc_valid) prev_a_d = cur_a;
      if (ext_edge) pend_d = 1'b1;
      if (take) begin
        pend_d = 1'b0;
        scnt_d = LEN_W'(1);
        dcnt_d = '0;
      end
    end
    if (state_q == CAPTURE) begin
      if (cfg_abort) abort_d = 1'b1;
      else if (adc_valid) dcnt_d = cap_tick ? '0 : dcnt_q + 8'd1;
      if (take) scnt_d = scnt_q + LEN_W'(1);
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = &drop_q ? drop_q : drop_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= TRIG_IMM;
      thr_q    <= '0;
      len_q    <= '0;
      decim_q  <= '0;
      cont_q   <= 1'b0;
      abort_q  <= 1'b0;
      pend_q   <= 1'b0;
      ext_q    <= 1'b0;
      prev_a_q <= '0;
      scnt_q   <= '0;
      dcnt_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      thr_q    <= thr_d;
      len_q    <= len_d;
      decim_q  <= decim_d;
      cont_q   <= cont_d;
      abort_q  <= abort_d;
      pend_q   <= pend_d;
      ext_q    <= ext_trig;
      prev_a_q <= prev_a_d;
      scnt_q   <= scnt_d;
      dcnt_q   <= dcnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for the ADC capture sequencer.
module tb_adc_capture_ctrl;
  localparam int DATA_W = 14;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_arm, cfg_abort, cfg_continuous, adc_valid, ext_trig, m_axis_tready;
  logic [1:0]        cfg_mode;
  logic [DATA_W-1:0] cfg_threshold, adc_data_a, adc_data_b;
  logic [LEN_W-1:0]  cfg_frame_len, drop_count;
  logic [7:0]        cfg_decim;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast, busy, done, aborted, overflow;
  logic [2:0]        state_o;

  always #5 clk = ~clk;

  adc_capture_ctrl #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_W     (LEN_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_mode      (cfg_mode),
    .cfg_threshold (cfg_threshold),
    .cfg_frame_len (cfg_frame_len),
    .cfg_decim     (cfg_decim),
    .cfg_continuous(cfg_continuous),
    .adc_data_a    (adc_data_a),
    .adc_data_b    (adc_data_b),
    .adc_valid     (adc_valid),
    .ext_trig      (ext_trig),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .state_o       (state_o)
  );

  logic [32:0] exp_q[$];
  logic [32:0] hold_v;
  int          n_chk = 0, n_pass = 0, done_cnt = 0, abort_cnt = 0, rdy_mode = 0, n;
  bit          prev_last_hs = 0, hold = 0, watch_busy = 0, busy_dropped = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected stream word: {tlast, 16-bit b, 16-bit a} with b = -a-1 as driven.
  function automatic logic [32:0] beat(input int a, input bit last);
    int b = -a - 1;
    return {last, 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_rdy(input int m);
    rdy_mode = m;
    m_axis_tready = (m == 1);
  endtask

  task automatic drive(input bit v, input int a, input bit ext = 1'b0, input bit ab = 1'b0);
    adc_valid  = v;
    adc_data_a = 14'(a);
    adc_data_b = 14'(-a - 1);
    ext_trig   = ext;
    cfg_abort  = ab;
    tick();
    adc_valid = 1'b0;
    ext_trig  = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic arm(input int mode, input int thr, input int len, input int decim, input bit cont);
    cfg_mode       = 2'(mode);
    cfg_threshold  = 14'(thr);
    cfg_frame_len  = 16'(len);
    cfg_decim      = 8'(decim);
    cfg_continuous = cont;
    cfg_arm        = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k = 0;
    while (state_o !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, state_o, s);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_last_hs) check("done_after_tlast", done, 1);
      if (hold && m_axis_tvalid) check("axis_stable", {m_axis_tlast, m_axis_tdata}, hold_v);
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (watch_busy && !busy) busy_dropped = 1;
      prev_last_hs = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("beat_queue", exp_q.size(), 1);
        else check("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        prev_last_hs = m_axis_tlast;
      end
      hold   = m_axis_tvalid && !m_axis_tready;
      hold_v = {m_axis_tlast, m_axis_tdata};
    end else begin
      prev_last_hs = 0;
      hold = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cfg_arm = 0; cfg_abort = 0; cfg_mode = 0; cfg_threshold = 0; cfg_frame_len = 0;
    cfg_decim = 0; cfg_continuous = 0; adc_data_a = 0; adc_data_b = 0; adc_valid = 0;
    ext_trig = 0; m_axis_tready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {m_axis_tvalid, m_axis_tlast, busy, done, aborted, overflow}, 0);
    check("rst_state", state_o, 0);
    check("rst_drop", drop_count, 0);
    reset = 1'b0;
    set_rdy(1);
    tick();

    // immediate trigger, plain ramp
    arm(0, 0, 8, 0, 0);
    check("m0_armed", state_o, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(beat(i, i == 7));
      drive(1, i);
    end
    wait_state(0, 50, "m0_idle");
    check("m0_done_cnt", done_cnt, 1);
    check("m0_drop", drop_count, 0);
    check("m0_sb_empty", exp_q.size(), 0);

    // threshold trigger with decimation
    arm(1, 100, 4, 2, 0);
    for (int a = 90; a <= 120; a++) begin
      if (a == 100 || a == 103 || a == 106 || a == 109) exp_q.push_back(beat(a, a == 109));
      drive(1, a);
    end
    wait_state(0, 50, "thr_idle");
    check("thr_done_cnt", done_cnt, 2);
    check("thr_sb_empty", exp_q.size(), 0);

    // external trigger pending across invalid cycles
    arm(2, 0, 4, 0, 0);
    drive(1, 40);
    drive(1, 41);
    check("ext_no_trig", state_o, 1);
    drive(0, 0, 1);
    drive(0, 0);
    drive(0, 0);
    check("ext_pending", state_o, 1);
    for (int a = 50; a <= 54; a++) begin
      if (a <= 53) exp_q.push_back(beat(a, a == 53));
      drive(1, a, a == 52);
    end
    wait_state(0, 50, "ext_idle");
    check("ext_done_cnt", done_cnt, 3);
    check("ext_sb_empty", exp_q.size(), 0);

    // overflow with stalled sink: reserved slot keeps tlast
    set_rdy(0);
    arm(0, 0, 40, 0, 0);
    for (int a = 0; a < 40; a++) begin
      if (a < 15 || a == 39) exp_q.push_back(beat(a, a == 39));
      drive(1, a);
    end
    check("ovf_state", state_o, 3);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 24);
    check("ovf_tvalid", m_axis_tvalid, 1);
    repeat (3) tick();
    set_rdy(1);
    wait_state(0, 100, "ovf_drain");
    check("ovf_done_cnt", done_cnt, 4);
    check("ovf_sb_empty", exp_q.size(), 0);

    // continuous capture under random backpressure
    set_rdy(2);
    arm(0, 0, 4, 0, 1);
    check("cont_ovf_clr", {overflow, drop_count}, 0);
    watch_busy = 1;
    for (int f = 0; f < 3; f++) begin
      wait_state(1, 300, "cont_rearm");
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(beat(f * 10 + i, i == 3));
        drive(1, f * 10 + i);
      end
    end
    n = 0;
    while (done_cnt < 7 && n < 300) begin
      tick();
      n++;
    end
    check("cont_done_cnt", done_cnt, 7);
    wait_state(1, 10, "cont_final_armed");
    watch_busy = 0;
    check("cont_busy_held", busy_dropped, 0);
    set_rdy(1);
    drive(0, 0, 0, 1);
    check("armed_abort_state", state_o, 0);
    check("armed_abort_pulse", abort_cnt, 1);
    check("cont_sb_empty", exp_q.size(), 0);

    // abort mid-frame: partial frame drains without tlast
    set_rdy(0);
    arm(0, 0, 20, 0, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(beat(i, 0));
      drive(1, i);
    end
    drive(1, 5, 0, 1);
    check("abort_drain_state", state_o, 3);
    check("abort_no_done", done, 0);
    drive(1, 6);
    drive(1, 7);
    set_rdy(1);
    wait_state(0, 100, "abort_idle");
    check("abort_pulse_cnt", abort_cnt, 2);
    check("abort_done_cnt", done_cnt, 7);
    check("abort_sb_empty", exp_q.size(), 0);

    // frame length below minimum clamps to 2
    arm(0, 0, 1, 0, 0);
    for (int a = 200; a < 204; a++) begin
      if (a < 202) exp_q.push_back(beat(a, a == 201));
      drive(1, a);
    end
    wait_state(0, 50, "clamp_idle");
    check("clamp_done_cnt", done_cnt, 8);
    check("clamp_sb_empty", exp_q.size(), 0);

    // asynchronous reset while a beat is stalled
    set_rdy(0);
    arm(0, 0, 10, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 300 + i);
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    #2 reset = 1'b1;
    #1 check("rst_tvalid_now", m_axis_tvalid, 0);
    check("rst_state_now", state_o, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("post_rst", {m_axis_tvalid, busy, overflow, drop_count}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
